// File: rtl/register_file_n_pkg.sv
// Shared datapath sizing for the decode-stage register file.
package register_file_n_pkg;
   localparam int unsigned REG_WIDTH     = 32;
   localparam int unsigned REG_DEPTH     = 32;
   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned REG_ZERO_ADDR = 0;
endpackage

// File: rtl/register_file_n_register_n.sv
// WIDTH-bit storage register with synchronous clear taking priority over load enable.
module register_n #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end
endmodule

// File: rtl/register_file_n.sv
// Register file: one synchronous write port, two combinational read ports.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module register_file_n
   import register_file_n_pkg::*;
#(
   parameter int unsigned WIDTH    = REG_WIDTH,
   parameter int unsigned DEPTH    = REG_DEPTH,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata1,
   output logic [WIDTH-1:0]  rdata2
);
   localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO_ADDR);
   localparam bit HasZero = (ZERO_REG != 0);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [DEPTH-1:0] wen;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam bit IsZero = HasZero && (i == int'(REG_ZERO_ADDR));
      assign wen[i] = we && (waddr == ADDR_W'(i)) && !IsZero;

      register_n #(
         .WIDTH(WIDTH)
      ) u_reg (
         .clk(clk),
         .rst(rst),
         .en (wen[i]),
         .d  (wdata),
         .q  (entries[i])
      );
   end

`ifdef REGFILE_BYPASS_EN
   logic bypass_ok;
   // Forward only writes that will actually land in storage.
   assign bypass_ok = we && !rst && !(HasZero && waddr == ZeroAddr);
`endif

   always_comb begin
      rdata1 = entries[raddr1];
      if (HasZero && raddr1 == ZeroAddr) begin
         rdata1 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (bypass_ok && raddr1 == waddr) begin
         rdata1 = wdata;
      end
`endif
   end

   always_comb begin
      rdata2 = entries[raddr2];
      if (HasZero && raddr2 == ZeroAddr) begin
         rdata2 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (bypass_ok && raddr2 == waddr) begin
         rdata2 = wdata;
      end
`endif
   end
endmodule

// File: tb/tb_register_file_n.sv
// Directed bench for register_file_n: default, ZERO_REG=0 and small-parameter instances.
module tb_register_file_n;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata1, rdata2, nz_rdata1, nz_rdata2;

   logic       s_we = 1'b0;
   logic [1:0] s_waddr = '0;
   logic [7:0] s_wdata = '0;
   logic [1:0] s_raddr1 = '0;
   logic [1:0] s_raddr2 = '0;
   logic [7:0] s_rdata1, s_rdata2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   register_file_n dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
   );

   register_file_n #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(nz_rdata1), .rdata2(nz_rdata2)
   );

   register_file_n #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1)) dut_small (
      .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
      .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] n1;
      logic [31:0] n2;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"wr7",       1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd0,
                  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{"wr31",      1'b1, 5'd31, 32'h1234_5678, 5'd7,  5'd31,
                  32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
      vecs[2] = '{"same_addr", 1'b0, 5'd0,  32'h0,         5'd7,  5'd7,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[3] = '{"wr0",       1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd7,
                  32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
      vecs[4] = '{"wr3",       1'b1, 5'd3,  32'h0000_0011, 5'd3,  5'd31,
                  32'h11, 32'h1234_5678, 32'h11, 32'h1234_5678};
      vecs[5] = '{"we_low",    1'b0, 5'd3,  32'h0000_0099, 5'd3,  5'd3,
                  32'h11, 32'h11, 32'h11, 32'h11};
      vecs[6] = '{"wr30",      1'b1, 5'd30, 32'hCAFE_F00D, 5'd30, 5'd29,
                  32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'h0};

      // Initial reset, then preload and clear (test 1)
      pulse_reset();
      for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5_0000 + 32'(i));
      raddr1 = 5'd17; raddr2 = 5'd31; #1;
      check("preload_17", rdata1, 32'hA5A5_0011);
      check("preload_31", rdata2, 32'hA5A5_001F);
      pulse_reset();
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
         check($sformatf("rst_clr_p1_%0d", i), rdata1, 32'h0);
         check($sformatf("rst_clr_p2_%0d", 31 - i), rdata2, 32'h0);
         check($sformatf("rst_clr_nz_%0d", i), nz_rdata1, 32'h0);
      end

      // Table-driven write/read vectors
      foreach (vecs[k]) begin
         @(negedge clk);
         we = vecs[k].we; waddr = vecs[k].waddr; wdata = vecs[k].wdata;
         raddr1 = vecs[k].ra1; raddr2 = vecs[k].ra2;
         @(posedge clk); #1;
         we = 1'b0; #1;
         check({vecs[k].name, "_r1"}, rdata1, vecs[k].e1);
         check({vecs[k].name, "_r2"}, rdata2, vecs[k].e2);
         check({vecs[k].name, "_nz_r1"}, nz_rdata1, vecs[k].n1);
         check({vecs[k].name, "_nz_r2"}, nz_rdata2, vecs[k].n2);
      end

      // Read-during-write on entry 3 (holds 0x11)
      @(negedge clk);
      we = 1'b1; waddr = 5'd3; wdata = 32'h22; raddr1 = 5'd3; raddr2 = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
      check("rdw_before_edge", rdata1, 32'h22);
`else
      check("rdw_before_edge", rdata1, 32'h11);
`endif
      check("rdw_other_port", rdata2, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      we = 1'b0; #1;
      check("rdw_after_edge", rdata1, 32'h22);

      // Write to address 0 in flight: never forwarded when ZERO_REG=1
      @(negedge clk);
      we = 1'b1; waddr = 5'd0; wdata = 32'h5A5A_5A5A; raddr1 = 5'd0; #1;
      check("zero_no_bypass", rdata1, 32'h0);
`ifdef REGFILE_BYPASS_EN
      check("nz_zero_rdw", nz_rdata1, 32'h5A5A_5A5A);
`else
      check("nz_zero_rdw", nz_rdata1, 32'hFFFF_FFFF);
`endif
      @(posedge clk); #1;
      we = 1'b0; #1;
      check("zero_after_wr", rdata1, 32'h0);
      check("nz_zero_after_wr", nz_rdata1, 32'h5A5A_5A5A);

      // rst beats we; reads during the reset cycle show stored contents
      write_reg(5'd5, 32'h77);
      @(negedge clk);
      rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h55; raddr1 = 5'd5; raddr2 = 5'd3; #1;
      check("rst_cycle_r1", rdata1, 32'h77);
      check("rst_cycle_r2", rdata2, 32'h22);
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0; #1;
      check("rst_prio_e5", rdata1, 32'h0);
      check("rst_prio_e3", rdata2, 32'h0);
      check("rst_prio_nz_e5", nz_rdata1, 32'h0);

      // Small instance: WIDTH=8, DEPTH=4
      @(negedge clk);
      s_we = 1'b1; s_waddr = 2'd3; s_wdata = 8'hFF;
      @(negedge clk);
      s_waddr = 2'd1; s_wdata = 8'h01;
      @(negedge clk);
      s_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_s;
         exp_s = (i == 3) ? 8'hFF : (i == 1) ? 8'h01 : 8'h00;
         s_raddr1 = 2'(i); s_raddr2 = 2'(3 - i); #1;
         check($sformatf("small_p1_%0d", i), {24'h0, s_rdata1}, {24'h0, exp_s});
      end
      s_raddr2 = 2'd3; #1;
      check("small_p2_3", {24'h0, s_rdata2}, 32'h0000_00FF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
